// File: rtl/rpsc_fault_bank_if.sv
// Fault-bank signal bundle: raw inputs, masks, lamp test and the filtered/latched alarm outputs.
interface rpsc_fault_bank_if #(
  parameter int NCH = 8
);
  localparam int ID_W = (NCH > 1) ? $clog2(NCH) : 1;

  logic            LA_Test;
  logic            clr;
  logic [NCH-1:0]  in;
  logic [NCH-1:0]  mask;
  logic [NCH-1:0]  out;
  logic [NCH-1:0]  LA;
  logic            trip;
  logic [ID_W-1:0] first_id;
  logic            first_vld;

  modport master (
    output LA_Test, clr, in, mask,
    input  out, LA, trip, first_id, first_vld
  );

  modport slave (
    input  LA_Test, clr, in, mask,
    output out, LA, trip, first_id, first_vld
  );
endinterface

// File: rtl/rpsc_fault_bank.sv
// Per-channel synchronise/qualify/latch fault bank with lamp test and trip summary.
// Optional first-out capture is built when RPSC_FIRST_FAULT_EN is defined.
module rpsc_fault_bank #(
  parameter int NCH      = 8,
  parameter int FILT_CNT = 3,
  parameter int FILT_W   = 8
) (
  input  logic                clk,
  input  logic                reset,
  rpsc_fault_bank_if.slave    bus
);

  localparam int ID_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [FILT_W-1:0] FILT_MAX = FILT_W'(FILT_CNT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    QUAL   = 2'd1,
    ACTIVE = 2'd2
  } filt_state_t;

  logic [NCH-1:0]    sync1_q, sync1_d;
  logic [NCH-1:0]    sync2_q, sync2_d;
  filt_state_t       state_q [NCH];
  filt_state_t       state_d [NCH];
  logic [FILT_W-1:0] cnt_q   [NCH];
  logic [FILT_W-1:0] cnt_d   [NCH];
  logic [NCH-1:0]    out_q, out_d;
  logic [NCH-1:0]    latch_q, latch_d;

  function automatic logic [FILT_W-1:0] sat_inc(input logic [FILT_W-1:0] c);
    return (c >= FILT_MAX) ? FILT_MAX : c + 1'b1;
  endfunction

  always_comb begin
    sync1_d = bus.in;
    sync2_d = sync1_q;
    for (int i = 0; i < NCH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      out_d[i]   = out_q[i];
      case (state_q[i])
        IDLE: begin
          if (sync2_q[i]) begin
            state_d[i] = QUAL;
            cnt_d[i]   = FILT_W'(1);
          end
        end
        QUAL: begin
          if (sync2_q[i]) begin
            cnt_d[i] = sat_inc(cnt_q[i]);
            if (sat_inc(cnt_q[i]) == FILT_MAX) begin
              state_d[i] = ACTIVE;
              out_d[i]   = 1'b1;
            end
          end else begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
            out_d[i]   = 1'b0;
          end
        end
        ACTIVE: begin
          // Release is immediate: no filtering on the falling side.
          if (!sync2_q[i]) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
            out_d[i]   = 1'b0;
          end
        end
        default: begin
          state_d[i] = IDLE;
          cnt_d[i]   = '0;
          out_d[i]   = 1'b0;
        end
      endcase
    end
    // Set term is OR'd last so a set beats a clear on the same channel.
    latch_d = (latch_q & ~({NCH{bus.clr}} & ~out_q)) | (out_d & ~bus.mask);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      out_q   <= '0;
      latch_q <= '0;
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      out_q   <= out_d;
      latch_q <= latch_d;
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  assign bus.out  = out_q;
  assign bus.LA   = latch_q | {NCH{bus.LA_Test}};
  assign bus.trip = |latch_q;

`ifdef RPSC_FIRST_FAULT_EN
  logic [ID_W-1:0] first_id_q, first_id_d;
  logic            first_vld_q, first_vld_d;

  function automatic logic [ID_W-1:0] lowest_idx(input logic [NCH-1:0] v);
    logic [ID_W-1:0] idx;
    idx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (v[i]) idx = ID_W'(i);
    end
    return idx;
  endfunction

  // Capture only on the empty-to-nonempty transition; drop once everything is cleared.
  always_comb begin
    first_id_d  = first_id_q;
    first_vld_d = first_vld_q;
    if (latch_d == '0) begin
      first_id_d  = '0;
      first_vld_d = 1'b0;
    end else if (latch_q == '0) begin
      first_id_d  = lowest_idx(latch_d);
      first_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      first_id_q  <= '0;
      first_vld_q <= 1'b0;
    end else begin
      first_id_q  <= first_id_d;
      first_vld_q <= first_vld_d;
    end
  end

  assign bus.first_id  = first_id_q;
  assign bus.first_vld = first_vld_q;
`else
  assign bus.first_id  = '0;
  assign bus.first_vld = 1'b0;
`endif

endmodule
